hier_node_dispatch: RTL and testbench

// - Parametrised hierarchy node. Replaces fixed wrappers that hard-instantiate five portless children.
// - Drives NUM_CHILD child leaves through a start/done handshake, in sequential or parallel mode.
// - Reports aggregate completion and child timeout to its parent node.
// - Sits at every non-leaf level of the generated module tree; nodes chain via start_i/done_o.

---
 rtl/hier_node_pkg.sv | 9 +
 rtl/hier_node_if.sv | 27 ++
 rtl/hier_node_watchdog.sv | 22 ++
 rtl/hier_node_dispatch.sv | 114 +++++++++++
 tb/tb_hier_node_dispatch.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hier_node_pkg.sv
// Shared types for the hierarchy dispatch node: FSM states, run mode, child limit.
package hier_node_pkg;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, NEXT, DONE} node_state_e;
    typedef enum logic {MODE_SEQ, MODE_PAR} node_mode_e;

    localparam int MAX_CHILD = 32;

endpackage

// File: rtl/hier_node_if.sv
// Parent/child handshake bundle of one hierarchy node.
// slave = the node itself, master = whoever drives start/done (parent + children).
interface hier_node_if #(
    parameter int NUM_CHILD = 5,
    parameter int CNT_W     = 8,
    parameter int ID_W      = $clog2(NUM_CHILD) + 1
);
    logic                 start_i;
    logic                 mode_i;
    logic [CNT_W-1:0]     timeout_i;
    logic [NUM_CHILD-1:0] child_start_o;
    logic [NUM_CHILD-1:0] child_done_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 err_o;
    logic [ID_W-1:0]      cur_child_o;

    modport slave (
        input  start_i, mode_i, timeout_i, child_done_i,
        output child_start_o, busy_o, done_o, err_o, cur_child_o
    );

    modport master (
        output start_i, mode_i, timeout_i, child_done_i,
        input  child_start_o, busy_o, done_o, err_o, cur_child_o
    );
endinterface

// File: rtl/hier_node_watchdog.sv
// Wait-cycle counter for one child wait; flags when the count reaches a non-zero limit.
module hier_node_watchdog #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);
    logic [CNT_W-1:0] r_cnt;

    // Count enabled cycles from the last clear, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_cnt <= '0;
        else if (clr)                r_cnt <= '0;
        else if (en && r_cnt != '1)  r_cnt <= r_cnt + CNT_W'(1);
    end

    assign expired = en && (limit != '0) && (r_cnt == limit);
endmodule

// File: rtl/hier_node_dispatch.sv
// Hierarchy node: launches NUM_CHILD children sequentially or in parallel via
// start/done pulses and reports aggregate completion to its parent.
// Optional watchdog: define HIER_NODE_TIMEOUT_EN to enable per-wait timeout and err_o.
module hier_node_dispatch
    import hier_node_pkg::*;
#(
    parameter int NUM_CHILD = 5,
    parameter int CNT_W     = 8,
    parameter int ID_W      = $clog2(NUM_CHILD) + 1
) (
    input  logic        clk,
    input  logic        rst_n,
    hier_node_if.slave  node
);
    localparam logic [NUM_CHILD-1:0] ALL_CHILD = '1;

    node_state_e          r_state, w_next;
    node_mode_e           r_mode;
    logic [ID_W-1:0]      r_idx;
    logic [NUM_CHILD-1:0] r_pend;
    logic [NUM_CHILD-1:0] r_child_start;
    logic                 r_err;
    logic [NUM_CHILD-1:0] w_launch_mask;
    logic [NUM_CHILD-1:0] w_pend_left;
    logic                 w_accept;
    logic                 w_empty;
    logic                 w_expired;

    assign w_accept      = (r_state == IDLE) && node.start_i;
    assign w_pend_left   = r_pend & ~node.child_done_i;
    // The pulse cycle has an empty mask but is not a completion: pending loads only after it.
    assign w_empty       = (w_pend_left == '0) && (r_child_start == '0);
    assign w_launch_mask = (r_mode == MODE_PAR) ? ALL_CHILD : (NUM_CHILD'(1) << r_idx);

`ifdef HIER_NODE_TIMEOUT_EN
    logic [CNT_W-1:0] r_limit;

    // Timeout limit is captured with the request so the parent may change it afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_limit <= '0;
        else if (w_accept) r_limit <= node.timeout_i;
    end

    hier_node_watchdog #(.CNT_W(CNT_W)) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (r_state == LAUNCH),
        .en      (r_state == WAIT),
        .limit   (r_limit),
        .expired (w_expired)
    );
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^node.timeout_i;
    assign w_expired    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state and status outputs; a completion in the same cycle as expiry wins.
    always_comb begin
        w_next           = r_state;
        node.busy_o      = (r_state != IDLE);
        node.done_o      = (r_state == DONE);
        node.cur_child_o = '0;
        if (r_state != IDLE)
            node.cur_child_o = (r_mode == MODE_PAR) ? ID_W'(NUM_CHILD) : r_idx;
        unique case (r_state)
            IDLE:    if (node.start_i) w_next = LAUNCH;
            LAUNCH:  w_next = WAIT;
            WAIT:    if (w_empty)        w_next = NEXT;
                     else if (w_expired) w_next = DONE;
            NEXT:    if (r_mode == MODE_SEQ && r_idx < ID_W'(NUM_CHILD - 1)) w_next = LAUNCH;
                     else                                                    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request capture, child index, start pulses, pending mask and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode        <= MODE_SEQ;
            r_idx         <= '0;
            r_pend        <= '0;
            r_child_start <= '0;
            r_err         <= 1'b0;
        end else begin
            r_child_start <= (r_state == LAUNCH) ? w_launch_mask : '0;
            if (w_accept) begin
                r_mode <= node_mode_e'(node.mode_i);
                r_idx  <= '0;
                r_err  <= 1'b0;
            end
            if (r_state == NEXT && w_next == LAUNCH)
                r_idx <= r_idx + ID_W'(1);
            if (r_state == WAIT) begin
                if (w_expired && !w_empty) begin
                    r_pend <= '0;
                    r_err  <= 1'b1;
                end else begin
                    r_pend <= w_pend_left | r_child_start;
                end
            end
        end
    end

    assign node.child_start_o = r_child_start;
    assign node.err_o         = r_err;
endmodule

// File: tb/tb_hier_node_dispatch.sv
// Scoreboard bench for hier_node_dispatch: the stimulus predicts every child start
// pulse and done_o from per-child answer delays; a monitor pops and compares.
module tb_hier_node_dispatch;
    import hier_node_pkg::*;

    localparam int N  = 5;
    localparam int CW = 8;
    localparam int IW = $clog2(N) + 1;
    localparam int NEVER = 1000000;
`ifdef HIER_NODE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef struct {
        bit           is_done;
        int           cyc;
        logic [N-1:0] mask;
        int           cur;
        bit           err;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   errors = 0;
    int   checks = 0;
    ev_t  exp_q[$];
    int   dly[N];      // answer delay per child after its start pulse; 0 = never answers
    int   due[N];      // absolute cycle of each child's pending done pulse, -1 = none
    int   spur_cyc = -1;
    logic [N-1:0] spur_mask = '0;

    hier_node_if #(.NUM_CHILD(N), .CNT_W(CW), .ID_W(IW)) bus ();

    hier_node_dispatch #(.NUM_CHILD(N), .CNT_W(CW), .ID_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .node  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void push_ev(bit d, int c, logic [N-1:0] m, int cur, bit err);
        ev_t e;
        e.is_done = d; e.cyc = c; e.mask = m; e.cur = cur; e.err = err;
        exp_q.push_back(e);
    endfunction

    // Child responders plus injected spurious dones.
    initial begin
        logic [N-1:0] v;
        bus.child_done_i = '0;
        for (int i = 0; i < N; i++) due[i] = -1;
        forever begin
            @(posedge clk); #1;
            v = '0;
            for (int i = 0; i < N; i++) v[i] = (due[i] == cyc);
            if (spur_cyc == cyc) v = v | spur_mask;
            bus.child_done_i = v;
        end
    end

    // Monitor: every start pulse or done_o must match the head of the expectation queue.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            if (bus.child_start_o != '0) begin
                for (int i = 0; i < N; i++)
                    if (bus.child_start_o[i]) due[i] = (dly[i] > 0) ? cyc + dly[i] : -1;
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    checks++; errors++;
                    $display("FAIL unexpected_start: got %b expected none (cycle %0d)", bus.child_start_o, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("start_cycle", 64'(cyc), 64'(e.cyc));
                    chk("start_mask", 64'(bus.child_start_o), 64'(e.mask));
                    chk("start_cur_child", 64'(bus.cur_child_o), 64'(e.cur));
                end
            end
            if (bus.done_o) begin
                if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done_o=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("done_err", 64'(bus.err_o), 64'(e.err));
                    chk("done_cur_child", 64'(bus.cur_child_o), 64'(e.cur));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Issue one request; the expected timeline follows from the per-child delays:
    // pulse 2 cycles after start, next pulse 3 cycles after a done, done_o 2 cycles
    // after the last done, or 1 cycle after the limit when a child stays silent too long.
    task automatic run_txn(input bit par, input int tmo, input int bs_off,
                           input int spur_off, input logic [N-1:0] spur_m);
        int s, t, dc, et, d, m, cur;
        bit err;
        s   = cyc;
        t   = s + 2;
        et  = TMO_EN ? tmo : 0;
        err = 1'b0;
        dc  = 0;
        cur = 0;
        if (par) begin
            push_ev(0, t, '1, N, 0);
            m = 0;
            for (int i = 0; i < N; i++) begin
                d = (dly[i] == 0) ? NEVER : dly[i];
                if (d > m) m = d;
            end
            cur = N;
            if (et != 0 && m > et) begin dc = t + et + 1; err = 1'b1; end
            else                          dc = t + m + 2;
        end else begin
            for (int i = 0; i < N; i++) begin
                push_ev(0, t, N'(1) << i, i, 0);
                d   = (dly[i] == 0) ? NEVER : dly[i];
                cur = i;
                if (et != 0 && d > et) begin dc = t + et + 1; err = 1'b1; break; end
                if (i == N - 1) dc = t + d + 2;
                else            t  = t + d + 3;
            end
        end
        push_ev(1, dc, '0, cur, err);

        bus.mode_i = par; bus.timeout_i = CW'(tmo); bus.start_i = 1'b1;
        if (spur_off > 0) begin spur_cyc = s + spur_off; spur_mask = spur_m; end
        tick();
        bus.start_i = 1'b0;
        chk("busy_after_start", 64'(bus.busy_o), 64'd1);
        chk("err_cleared_on_start", 64'(bus.err_o), 64'd0);
        if (bs_off > 0) begin
            while (cyc < s + bs_off) tick();
            bus.start_i = 1'b1; bus.mode_i = ~par;
            tick();
            bus.start_i = 1'b0;
        end
        while (cyc < dc + 1 && cyc < s + 4000) tick();
        chk("idle_busy", 64'(bus.busy_o), 64'd0);
        chk("idle_err_sticky", 64'(bus.err_o), 64'(err));
        chk("idle_cur_child", 64'(bus.cur_child_o), 64'd0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        for (int i = 0; i < N; i++) due[i] = -1;
        spur_cyc = -1;
    endtask

    task automatic set_dly(input int a, input int b, input int c, input int d, input int e);
        dly[0] = a; dly[1] = b; dly[2] = c; dly[3] = d; dly[4] = e;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        int tmo;
        bit par;
        bus.start_i = 1'b0; bus.mode_i = 1'b0; bus.timeout_i = '0;
        set_dly(1, 1, 1, 1, 1);
        repeat (2) tick();
        chk("rst_child_start", 64'(bus.child_start_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_done", 64'(bus.done_o), 64'd0);
        chk("rst_err", 64'(bus.err_o), 64'd0);
        chk("rst_cur_child", 64'(bus.cur_child_o), 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Sequential walk, every child answers 3 cycles after its start.
        set_dly(3, 3, 3, 3, 3);
        run_txn(0, 0, 0, 0, '0);

        // Parallel: dones from 3, 0, 4, then 1 and 2 together.
        set_dly(2, 5, 5, 1, 3);
        run_txn(1, 0, 0, 0, '0);

        if (TMO_EN) begin
            // Child 2 stays silent: later children must never start.
            set_dly(3, 3, 0, 3, 3);
            run_txn(0, 10, 0, 0, '0);
            set_dly(2, 2, 2, 2, 2);
            run_txn(0, 10, 0, 0, '0);
        end

        // Done from a non-pending child and start_i while busy are both ignored.
        set_dly(3, 3, 3, 3, 3);
        run_txn(0, 0, 4, 4, 5'b01000);

        // Asynchronous reset during a parallel wait.
        set_dly(20, 20, 20, 20, 20);
        begin
            int s;
            s = cyc;
            push_ev(0, s + 2, '1, N, 0);
            bus.mode_i = 1'b1; bus.timeout_i = '0; bus.start_i = 1'b1;
            tick();
            bus.start_i = 1'b0;
            while (cyc < s + 6) tick();
            rst_n = 1'b0;
            #1;
            chk("midrst_child_start", 64'(bus.child_start_o), 64'd0);
            chk("midrst_busy", 64'(bus.busy_o), 64'd0);
            chk("midrst_cur_child", 64'(bus.cur_child_o), 64'd0);
            chk("midrst_start_seen", 64'(exp_q.size()), 64'd0);
            for (int i = 0; i < N; i++) due[i] = -1;
            exp_q.delete();
            tick();
            rst_n = 1'b1;
            tick();
        end
        set_dly(2, 5, 5, 1, 3);
        run_txn(1, 0, 0, 0, '0);

        // Short limit with a slow child (only an error when the watchdog is built in).
        set_dly(8, 1, 1, 1, 1);
        run_txn(0, 1, 0, 0, '0);

        // Randomized requests.
        for (int k = 0; k < 20; k++) begin
            par = 1'($urandom_range(0, 1));
            if (TMO_EN) tmo = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 8));
            else        tmo = int'($urandom_range(0, 255));
            for (int i = 0; i < N; i++) dly[i] = int'($urandom_range(1, 6));
            if (TMO_EN && tmo != 0 && $urandom_range(0, 3) == 0)
                dly[$urandom_range(0, N - 1)] = 0;
            run_txn(par, tmo, 0, 0, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
